// File: rtl/froc_trace_checker_if.sv
// Trace-checker bundle: FRoC controller observation, golden-memory read port and verdict outputs.
// master = environment (FRoC stimulus + golden memory), slave = checker.
interface froc_trace_checker_if #(
  parameter int NUM_SINKS = 8,
  parameter int STATE_W   = 8,
  parameter int ADDR_W    = 10
) ();
  logic                 start;
  logic                 done;
  logic                 error;
  logic [STATE_W-1:0]   state;
  logic [NUM_SINKS-1:0] sinks;
  logic [ADDR_W:0]      exp_count;
  logic [ADDR_W-1:0]    exp_addr;
  logic [NUM_SINKS-1:0] exp_data;
  logic                 busy;
  logic                 result_valid;
  logic                 pass;
  logic [15:0]          mismatch_count;
  logic [ADDR_W:0]      first_mm_index;
  logic [NUM_SINKS-1:0] first_mm_mask;
  logic                 overrun;
  logic                 underrun;
  logic                 err_seen;

  modport master (
    output start, done, error, state, sinks, exp_count, exp_data,
    input  exp_addr, busy, result_valid, pass, mismatch_count,
           first_mm_index, first_mm_mask, overrun, underrun, err_seen
  );

  modport slave (
    input  start, done, error, state, sinks, exp_count, exp_data,
    output exp_addr, busy, result_valid, pass, mismatch_count,
           first_mm_index, first_mm_mask, overrun, underrun, err_seen
  );
endinterface

// File: rtl/froc_trace_checker.sv
// Compares FRoC sink values against a golden trace; one entry per non-reset-phase RUN cycle.
// Golden read is issued one cycle ahead (exp_addr from next pointer); no backpressure, verdict held in DONE.
module froc_trace_checker #(
  parameter int NUM_SINKS       = 8,
  parameter int STATE_W         = 8,
  parameter int MIN_RESET_VALUE = 200,
  parameter int ADDR_W          = 10
) (
  input logic                 CLK,
  input logic                 reset,
  froc_trace_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} fsm_t;

  localparam logic [STATE_W-1:0] RST_TH  = STATE_W'(MIN_RESET_VALUE);
  localparam logic [ADDR_W:0]    PTR_ONE = (ADDR_W+1)'(1);

  fsm_t                 fsm;
  logic [ADDR_W:0]      ptr;
  logic [ADDR_W:0]      ptr_nxt;
  logic [ADDR_W:0]      cnt_q;
  logic                 busy_q;
  logic                 rv_q;
  logic                 pass_q;
  logic [15:0]          mm_q;
  logic [ADDR_W:0]      fidx_q;
  logic [NUM_SINKS-1:0] fmask_q;
  logic                 ovr_q;
  logic                 udr_q;
  logic                 err_q;

  logic                 active;
  logic                 cmp_cyc;
  logic                 at_end;
  logic [NUM_SINKS-1:0] diff;
  logic                 mm_hit;
  logic                 ur_hit;

  assign active  = (fsm == ARM) || (fsm == RUN);
  // ARM with start/done low behaves as the first RUN cycle, so it is a compare candidate too
  assign cmp_cyc = active && !bus.start && !bus.done && (bus.state <= RST_TH);
  assign at_end  = (ptr == cnt_q);
  assign diff    = bus.sinks ^ bus.exp_data;
  assign mm_hit  = cmp_cyc && !at_end && (|diff);
  assign ur_hit  = (fsm == RUN) && (ptr < cnt_q);

  always_comb begin
    ptr_nxt = ptr;
    if (bus.start) begin
      ptr_nxt = '0;
    end else if (cmp_cyc && !at_end) begin
      ptr_nxt = ptr + PTR_ONE;
    end
  end

  // Address the entry the pointer will hold next cycle, so exp_data lines up with ptr.
  assign bus.exp_addr = ptr_nxt[ADDR_W-1:0];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fsm     <= IDLE;
      ptr     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= '0;
      fidx_q  <= '0;
      fmask_q <= '0;
      ovr_q   <= 1'b0;
      udr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr <= ptr_nxt;
      if (bus.start) begin
        fsm     <= ARM;
        cnt_q   <= bus.exp_count;
        busy_q  <= 1'b1;
        rv_q    <= 1'b0;
        pass_q  <= 1'b0;
        mm_q    <= '0;
        fidx_q  <= '0;
        fmask_q <= '0;
        ovr_q   <= 1'b0;
        udr_q   <= 1'b0;
        err_q   <= 1'b0;
      end else if (active && bus.done) begin
        fsm    <= DONE;
        busy_q <= 1'b0;
        rv_q   <= 1'b1;
        if (ur_hit) begin
          udr_q <= 1'b1;
        end
        pass_q <= (mm_q == 16'd0) && !ovr_q && !err_q && !(udr_q || ur_hit);
      end else if (active) begin
        fsm <= RUN;
        if (cmp_cyc) begin
          if (bus.error) begin
            err_q <= 1'b1;
          end
          if (at_end) begin
            ovr_q <= 1'b1;
          end
          if (mm_hit) begin
            if (mm_q == 16'd0) begin
              fidx_q  <= ptr;
              fmask_q <= diff;
            end
            if (mm_q != 16'hFFFF) begin
              mm_q <= mm_q + 16'd1;
            end
          end
        end
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.result_valid   = rv_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = mm_q;
  assign bus.first_mm_index = fidx_q;
  assign bus.first_mm_mask  = fmask_q;
  assign bus.overrun        = ovr_q;
  assign bus.underrun       = udr_q;
  assign bus.err_seen       = err_q;

endmodule

// File: tb/tb_froc_trace_checker.sv
// Directed bench for froc_trace_checker: trace-level reference model checked every cycle,
// plus literal verdict expectations per scenario.
module tb_froc_trace_checker;

  localparam int NS  = 8;
  localparam int SW  = 8;
  localparam int MRV = 200;
  localparam int AW  = 17;

  logic CLK;
  logic reset;

  froc_trace_checker_if #(.NUM_SINKS(NS), .STATE_W(SW), .ADDR_W(AW)) bus ();

  froc_trace_checker #(
    .NUM_SINKS(NS), .STATE_W(SW), .MIN_RESET_VALUE(MRV), .ADDR_W(AW)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [7:0] gold_arr [0:3] = '{8'h01, 8'h02, 8'h04, 8'h08};

  function automatic logic [7:0] gold_rd(input int a);
    if (a < 4) return gold_arr[a];
    return 8'hA5;
  endfunction

  // Golden memory: one-cycle registered read
  always @(posedge CLK) bus.exp_data <= gold_rd(int'(bus.exp_addr));

  // Reference model: 0 idle, 1 armed/running, 2 verdict
  int  m_phase, m_ptr, m_cnt, m_mm, m_fidx;
  bit  m_run, m_ovr, m_udr, m_err;
  logic [7:0] m_fmask;

  task automatic model_clear();
    m_phase = 0; m_run = 0; m_ptr = 0; m_cnt = 0; m_mm = 0; m_fidx = 0;
    m_fmask = 8'h00; m_ovr = 0; m_udr = 0; m_err = 0;
  endtask

  task automatic model_step(input bit s, input bit d, input bit e,
                            input int st, input logic [7:0] sk, input int cnt);
    logic [7:0] want;
    if (s) begin
      model_clear();
      m_phase = 1;
      m_cnt   = cnt;
    end else if (m_phase == 1) begin
      if (d) begin
        if (m_run && m_ptr < m_cnt) m_udr = 1;
        m_phase = 2;
      end else begin
        m_run = 1;
        if (st <= MRV) begin
          if (e) m_err = 1;
          if (m_ptr == m_cnt) begin
            m_ovr = 1;
          end else begin
            want = gold_rd(m_ptr);
            if (sk != want) begin
              if (m_mm == 0) begin
                m_fidx  = m_ptr;
                m_fmask = sk ^ want;
              end
              if (m_mm < 65535) m_mm++;
            end
            m_ptr++;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, 2 time units after the rising edge
  always @(posedge CLK) begin
    #2;
    if (chk_en) begin
      chk("busy",     32'(bus.busy),           32'(m_phase == 1));
      chk("rvalid",   32'(bus.result_valid),   32'(m_phase == 2));
      chk("pass",     32'(bus.pass),
          32'((m_phase == 2) && m_mm == 0 && !m_ovr && !m_udr && !m_err));
      chk("mm_count", 32'(bus.mismatch_count), 32'(m_mm));
      chk("fidx",     32'(bus.first_mm_index), 32'(m_fidx));
      chk("fmask",    32'(bus.first_mm_mask),  32'(m_fmask));
      chk("overrun",  32'(bus.overrun),        32'(m_ovr));
      chk("underrun", 32'(bus.underrun),       32'(m_udr));
      chk("err_seen", 32'(bus.err_seen),       32'(m_err));
    end
  end

  task automatic step(input bit s, input bit d, input bit e, input int st, input logic [7:0] sk);
    bus.start = s;
    bus.done  = d;
    bus.error = e;
    bus.state = 8'(st);
    bus.sinks = sk;
    @(posedge CLK);
    if (reset === 1'b0) model_clear();
    else model_step(s, d, e, st, sk, int'(bus.exp_count));
    #3;
  endtask

  task automatic clean_trace();
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, gold_rd(i));
    step(0, 1, 0, 0, 8'h00);
  endtask

  initial begin
    model_clear();
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.done      = 1'b0;
    bus.error     = 1'b0;
    bus.state     = '0;
    bus.sinks     = '0;
    bus.exp_count = 18'd4;
    @(posedge CLK);
    #2;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_rvalid", 32'(bus.result_valid), 32'd0);
    chk("rst_mm",     32'(bus.mismatch_count), 32'd0);
    chk("rst_addr",   32'(bus.exp_addr), 32'd0);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Clean trace
    clean_trace();
    chk("s1_pass", 32'(bus.pass), 32'd1);
    chk("s1_mm",   32'(bus.mismatch_count), 32'd0);

    // Mismatch on entry 2
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, (i == 2) ? 8'h06 : gold_rd(i));
    step(0, 1, 0, 0, 8'h00);
    chk("s2_pass",  32'(bus.pass), 32'd0);
    chk("s2_mm",    32'(bus.mismatch_count), 32'd1);
    chk("s2_fidx",  32'(bus.first_mm_index), 32'd2);
    chk("s2_fmask", 32'(bus.first_mm_mask), 32'h02);

    // Reset-phase stall between entries 1 and 2, error only during reset phase
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, gold_rd(0));
    step(0, 0, 0, 0, gold_rd(1));
    step(0, 0, 1, MRV + 1, 8'hFF);
    step(0, 0, 1, MRV + 1, 8'h3C);
    step(0, 0, 0, 0, gold_rd(2));
    step(0, 0, 0, 0, gold_rd(3));
    step(0, 1, 0, 0, 8'h00);
    chk("s3_pass", 32'(bus.pass), 32'd1);
    chk("s3_err",  32'(bus.err_seen), 32'd0);

    // Overrun: five compare cycles
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, gold_rd(i));
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("s4_ovr",  32'(bus.overrun), 32'd1);
    chk("s4_pass", 32'(bus.pass), 32'd0);
    chk("s4_mm",   32'(bus.mismatch_count), 32'd0);

    // Underrun: three compare cycles then done
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, gold_rd(i));
    step(0, 1, 0, 0, 8'h00);
    chk("s5_udr",  32'(bus.underrun), 32'd1);
    chk("s5_pass", 32'(bus.pass), 32'd0);

    // Error on a compare cycle
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, (i == 1), 0, gold_rd(i));
    step(0, 1, 0, 0, 8'h00);
    chk("s6_err",  32'(bus.err_seen), 32'd1);
    chk("s6_pass", 32'(bus.pass), 32'd0);

    // Empty golden trace
    bus.exp_count = 18'd0;
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h01);
    step(0, 1, 0, 0, 8'h00);
    chk("s7_ovr", 32'(bus.overrun), 32'd1);

    // Abort and re-arm mid-run
    bus.exp_count = 18'd4;
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'hEE);
    step(0, 0, 0, 0, gold_rd(1));
    clean_trace();
    chk("s8_pass", 32'(bus.pass), 32'd1);
    chk("s8_mm",   32'(bus.mismatch_count), 32'd0);

    // Asynchronous reset mid-run after one mismatch
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h81);
    chk("s9_pre_mm", 32'(bus.mismatch_count), 32'd1);
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    chk("s9_busy",  32'(bus.busy), 32'd0);
    chk("s9_mm",    32'(bus.mismatch_count), 32'd0);
    chk("s9_fmask", 32'(bus.first_mm_mask), 32'd0);
    chk("s9_addr",  32'(bus.exp_addr), 32'd0);
    step(0, 0, 0, 0, gold_rd(1));
    #1;
    reset = 1'b1;
    step(0, 0, 0, 0, gold_rd(0));
    chk("s9_idle", 32'(bus.busy), 32'd0);
    clean_trace();
    chk("s9_pass", 32'(bus.pass), 32'd1);

    // Mismatch counter saturation
    bus.exp_count = 18'd70010;
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("s10_mm",    32'(bus.mismatch_count), 32'h0000FFFF);
    chk("s10_fidx",  32'(bus.first_mm_index), 32'd0);
    chk("s10_fmask", 32'(bus.first_mm_mask), 32'h01);
    chk("s10_pass",  32'(bus.pass), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/froc_trace_checker.md
FROC_TRACE_CHECKER -- requirements
Module: froc_trace_checker

Interface
REQ-001 Parameter NUM_SINKS, default 8, number of sink bits compared per cycle.
REQ-002 Parameter STATE_W, default 8, width of controller state.
REQ-003 Parameter MIN_RESET_VALUE, default 200, state threshold; state > MIN_RESET_VALUE marks a reset-phase cycle.
REQ-004 Parameter ADDR_W, default 10, golden-trace address width.
REQ-005 CLK  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  test start level, same meaning as the trace writer's start.
REQ-008 done  input  1  test done level.
REQ-009 error  input  1  FRoC circuit error flag.
REQ-010 state  input  STATE_W  FRoC controller state.
REQ-011 sinks  input  NUM_SINKS  current sink values.
REQ-012 exp_count  input  ADDR_W+1  number of golden entries; sampled at start.
REQ-013 exp_addr  output  ADDR_W  golden-memory read address (combinational from next pointer).
REQ-014 exp_data  input  NUM_SINKS  golden entry; valid 1 cycle after exp_addr.
REQ-015 busy  output  1  high in ARM or RUN.
REQ-016 result_valid  output  1  high in DONE.
REQ-017 pass  output  1  valid when result_valid.
REQ-018 mismatch_count  output  16  compared cycles that mismatched.
REQ-019 first_mm_index  output  ADDR_W+1  trace index of first mismatch.
REQ-020 first_mm_mask  output  NUM_SINKS  sinks XOR exp_data at first mismatch.
REQ-021 overrun, underrun, err_seen  outputs  1 each  sticky status flags.

Function
REQ-022 FSM states IDLE, ARM, RUN, DONE; priority per cycle: start > done > compare.
REQ-023 IDLE/DONE: start sampled high -> ARM; clear pointer, counters, flags, first_mm_*; latch exp_count.
REQ-024 ARM: stay while start high; start low and done low -> RUN with that cycle compared; start low and done high -> DONE.
REQ-025 exp_addr equals the next-cycle value of the pointer, so exp_data always holds entry[pointer]; exp_addr = 0 in IDLE/ARM.
REQ-026 RUN compare cycle (start low, done low, state <= MIN_RESET_VALUE): compare sinks to exp_data, pointer increments by 1.
REQ-027 Reset-phase cycle (state > MIN_RESET_VALUE): no compare, pointer unchanged, error ignored.
REQ-028 Mismatch: mismatch_count += 1, saturating at 16'hFFFF; on first mismatch only, capture pointer into first_mm_index and XOR into first_mm_mask.
REQ-029 error high on a compare cycle sets err_seen.
REQ-030 Compare cycle with pointer == latched exp_count: set overrun, no compare, no mismatch increment, pointer holds.
REQ-031 done high in RUN -> DONE; if pointer < latched exp_count set underrun; that cycle is not compared.
REQ-032 DONE: pass = (mismatch_count==0) & ~overrun & ~underrun & ~err_seen; all outputs held until next start.
REQ-033 start high in RUN aborts and re-arms per REQ-023; no result is produced.
REQ-034 exp_count == 0: first compare cycle sets overrun.

Reset
REQ-035 reset low asynchronously forces IDLE; busy, result_valid, pass, overrun, underrun, err_seen = 0; mismatch_count, first_mm_index, first_mm_mask, pointer = 0; exp_addr = 0.
REQ-036 Reset mid-RUN discards all results; reset release returns to IDLE and requires a new start.

Verification
REQ-037 exp_count=4, golden {0x01,0x02,0x04,0x08}; start 1 cycle, then 4 matching cycles, done -> pass=1, mismatch_count=0, all flags 0.
REQ-038 Same trace, cycle 2 sinks=0x06 -> pass=0, mismatch_count=1, first_mm_index=2, first_mm_mask=0x02.
REQ-039 Two reset-phase cycles (state=MIN_RESET_VALUE+1) inserted between entries 1 and 2 -> pointer stalls, pass=1.
REQ-040 exp_count=4: 5 compare cycles -> overrun=1, pass=0; 3 compare cycles then done -> underrun=1, pass=0.
REQ-041 error=1 on one compare cycle -> err_seen=1, pass=0; error=1 only during reset phase -> pass=1.
REQ-042 reset low mid-RUN after one mismatch -> all outputs 0 at once; new start with a clean trace -> pass=1; 70000 mismatches -> mismatch_count=16'hFFFF.
